// File: rtl/cache_mem_arb_pkg.sv
// Shared types and port indices for the cache/memory request arbiter.
package cache_mem_arb_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } arb_state_e;

  localparam int unsigned ICACHE_PORT = 0;
  localparam int unsigned DCACHE_PORT = 1;
  localparam int unsigned PTW_PORT    = 2;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_arbiter #(
  parameter int unsigned NrPorts = 3,
  parameter int unsigned PtrWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic [NrPorts-1:0]  req,
  input  logic [PtrWidth-1:0] ptr,
  output logic [NrPorts-1:0]  gnt
);

  logic found;

  // Outer loop walks the search distance from ptr so the nearest requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NrPorts; off++) begin
      for (int unsigned p = 0; p < NrPorts; p++) begin
        if (!found && req[p] && (ptr == PtrWidth'((p + NrPorts - off) % NrPorts))) begin
          gnt[p] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory request channel among icache, dcache and PTW with
// transaction-ID tagging, ID-based response routing and a drain sequence.
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int unsigned NrPorts  = 3,
  parameter int unsigned TidWidth = 2,
  parameter int unsigned ReqWidth = 128,
  parameter int unsigned RspWidth = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NrPorts-1:0]                 req_valid_i,
  input  logic [NrPorts-1:0][ReqWidth-1:0]   req_i,
  output logic [NrPorts-1:0]                 req_ready_o,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic [ReqWidth-1:0]                mem_req_o,
  output logic [TidWidth-1:0]                mem_req_tid_o,
  input  logic                               mem_rsp_valid_i,
  input  logic [TidWidth-1:0]                mem_rsp_tid_i,
  input  logic [RspWidth-1:0]                mem_rsp_i,
  output logic [NrPorts-1:0]                 rsp_valid_o,
  output logic [RspWidth-1:0]                rsp_o,
  input  logic                               drain_i,
  output logic                               drain_done_o,
  output logic                               busy_o
);

  localparam int unsigned NrTids = 2 ** TidWidth;
  localparam int unsigned PW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  arb_state_e          state_q, state_d;
  logic [NrTids-1:0]   id_busy_q, id_busy_d;
  logic [PW-1:0]       owner_q [NrTids];
  logic [PW-1:0]       rr_ptr_q;

  logic [NrPorts-1:0]  gnt;
  logic [PW-1:0]       win_idx;
  logic [TidWidth-1:0] free_tid;
  logic                any_free;
  logic                slot_free;
  logic                grant;
  logic                valid_d;
  logic                rsp_hit;
  logic [PW-1:0]       rsp_owner;

  rr_arbiter #(
    .NrPorts (NrPorts),
    .PtrWidth(PW)
  ) u_rr_arbiter (
    .req(req_valid_i),
    .ptr(rr_ptr_q),
    .gnt(gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (gnt[p]) win_idx = PW'(p);
    end
  end

  // Only IDs free in the current register state are allocatable; an ID
  // responding this cycle stays unavailable until the next edge.
  always_comb begin
    free_tid = '0;
    any_free = 1'b0;
    for (int unsigned t = 0; t < NrTids; t++) begin
      if (!id_busy_q[t] && !any_free) begin
        free_tid = TidWidth'(t);
        any_free = 1'b1;
      end
    end
  end

  assign slot_free   = !mem_req_valid_o || mem_req_ready_i;
  assign grant       = slot_free && any_free && (state_q == RUN) && (|req_valid_i);
  assign req_ready_o = grant ? gnt : '0;
  assign valid_d     = grant || (mem_req_valid_o && !mem_req_ready_i);

  assign rsp_hit   = mem_rsp_valid_i && id_busy_q[mem_rsp_tid_i];
  assign rsp_owner = owner_q[mem_rsp_tid_i];
  assign rsp_o     = mem_rsp_i;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      rsp_valid_o[p] = rsp_hit && (rsp_owner == PW'(p));
    end
  end

  always_comb begin
    id_busy_d = id_busy_q;
    if (rsp_hit) id_busy_d[mem_rsp_tid_i] = 1'b0;
    if (grant)   id_busy_d[free_tid]      = 1'b1;
  end

  // Drain completion looks at next-cycle occupancy so drain_done_o rises
  // the cycle right after the final response or slot acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_i) state_d = DRAIN;
      DRAIN: begin
        if (!drain_i)                        state_d = RUN;
        else if (!valid_d && id_busy_d == '0) state_d = DRAINED;
      end
      DRAINED: if (!drain_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= RUN;
      id_busy_q       <= '0;
      rr_ptr_q        <= '0;
      mem_req_valid_o <= 1'b0;
      drain_done_o    <= 1'b0;
    end else begin
      state_q         <= state_d;
      id_busy_q       <= id_busy_d;
      mem_req_valid_o <= valid_d;
      drain_done_o    <= (state_d == DRAINED);
      if (grant) begin
        mem_req_o         <= req_i[win_idx];
        mem_req_tid_o     <= free_tid;
        owner_q[free_tid] <= win_idx;
        rr_ptr_q          <= (win_idx == PW'(NrPorts - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign busy_o = (|id_busy_q) || mem_req_valid_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_rsp_valid_i) begin
      assert (id_busy_q[mem_rsp_tid_i])
        else $warning("cache_mem_arbiter: response on idle tid %0d dropped", mem_rsp_tid_i);
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  localparam int unsigned NrPorts  = 3;
  localparam int unsigned TidWidth = 2;
  localparam int unsigned ReqWidth = 128;
  localparam int unsigned RspWidth = 64;

  logic                             clk;
  logic                             rst;
  logic [NrPorts-1:0]               req_valid;
  logic [NrPorts-1:0][ReqWidth-1:0] req;
  logic [NrPorts-1:0]               req_ready;
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [ReqWidth-1:0]              mem_req;
  logic [TidWidth-1:0]              mem_req_tid;
  logic                             mem_rsp_valid;
  logic [TidWidth-1:0]              mem_rsp_tid;
  logic [RspWidth-1:0]              mem_rsp;
  logic [NrPorts-1:0]               rsp_valid;
  logic [RspWidth-1:0]              rsp;
  logic                             drain;
  logic                             drain_done;
  logic                             busy;

  int n_cmp = 0;
  int n_err = 0;

  cache_mem_arbiter #(
    .NrPorts (NrPorts),
    .TidWidth(TidWidth),
    .ReqWidth(ReqWidth),
    .RspWidth(RspWidth)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_i          (req),
    .req_ready_o    (req_ready),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_req_o      (mem_req),
    .mem_req_tid_o  (mem_req_tid),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_tid_i  (mem_rsp_tid),
    .mem_rsp_i      (mem_rsp),
    .rsp_valid_o    (rsp_valid),
    .rsp_o          (rsp),
    .drain_i        (drain),
    .drain_done_o   (drain_done),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst           = 1'b1;
    req_valid     = '0;
    req           = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_tid   = '0;
    mem_rsp       = '0;
    drain         = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
    n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (drain_done !== 1'b0)    begin n_err++; $display("FAIL reset_drain_done got %b exp 0", drain_done); end
    n_cmp++; if (req_ready !== 3'b000)   begin n_err++; $display("FAIL reset_req_ready got %b exp 000", req_ready); end
    n_cmp++; if (rsp_valid !== 3'b000)   begin n_err++; $display("FAIL reset_rsp_valid got %b exp 000", rsp_valid); end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 3'b010;
    req[1]    = 128'hA5;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_grant got %b exp 010", req_ready); end
    tick();
    req_valid     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_tid   = 2'd0;
    mem_rsp       = 64'h1234_5678_9ABC_DEF0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", mem_req_valid); end
    n_cmp++; if (mem_req_tid !== 2'd0)   begin n_err++; $display("FAIL single_tid got %0d exp 0", mem_req_tid); end
    n_cmp++; if (mem_req !== 128'hA5)    begin n_err++; $display("FAIL single_payload got %h exp a5", mem_req); end
    n_cmp++; if (rsp_valid !== 3'b010)   begin n_err++; $display("FAIL single_rsp_valid got %b exp 010", rsp_valid); end
    n_cmp++; if (rsp !== 64'h1234_5678_9ABC_DEF0) begin n_err++; $display("FAIL single_rsp_data got %h exp 123456789abcdef0", rsp); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_fairness();
    logic [TidWidth-1:0] exp_tid [6];
    exp_tid = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    apply_reset();
    for (int unsigned p = 0; p < NrPorts; p++) req[p] = ReqWidth'(32'h100 + p);
    req_valid = 3'b111;
    for (int unsigned c = 0; c < 6; c++) begin
      if (c > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = exp_tid[c-1];
      end
      #1;
      n_cmp++; if (req_ready !== 3'(1 << (c % 3))) begin n_err++; $display("FAIL fair_grant c%0d got %b exp %b", c, req_ready, 3'(1 << (c % 3))); end
      if (c > 0) begin
        n_cmp++; if (mem_req_tid !== exp_tid[c-1]) begin n_err++; $display("FAIL fair_tid c%0d got %0d exp %0d", c, mem_req_tid, exp_tid[c-1]); end
        n_cmp++; if (mem_req !== ReqWidth'(32'h100 + (c-1) % 3)) begin n_err++; $display("FAIL fair_payload c%0d got %h exp %h", c, mem_req, 32'h100 + (c-1) % 3); end
        n_cmp++; if (rsp_valid !== 3'(1 << ((c-1) % 3))) begin n_err++; $display("FAIL fair_rsp c%0d got %b exp %b", c, rsp_valid, 3'(1 << ((c-1) % 3))); end
      end
      tick();
    end
    req_valid     = '0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_exhaustion();
    apply_reset();
    mem_req_ready = 1'b1;
    req_valid     = 3'b001;
    req[0]        = 128'h77;
    for (int unsigned c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL exh_grant c%0d got %b exp 001", c, req_ready); end
      if (c > 0) begin
        n_cmp++; if (mem_req_tid !== TidWidth'(c - 1)) begin n_err++; $display("FAIL exh_tid c%0d got %0d exp %0d", c, mem_req_tid, c - 1); end
      end
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_tid   = 2'd2;
    #1;
    n_cmp++; if (mem_req_tid !== 2'd3)   begin n_err++; $display("FAIL exh_tid3 got %0d exp 3", mem_req_tid); end
    n_cmp++; if (req_ready !== 3'b000)   begin n_err++; $display("FAIL exh_full got %b exp 000", req_ready); end
    n_cmp++; if (rsp_valid !== 3'b001)   begin n_err++; $display("FAIL exh_rsp got %b exp 001", rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL exh_slot_empty got %b exp 0", mem_req_valid); end
    n_cmp++; if (req_ready !== 3'b001)   begin n_err++; $display("FAIL exh_reuse_grant got %b exp 001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (mem_req_tid !== 2'd2)   begin n_err++; $display("FAIL exh_reuse_tid got %0d exp 2", mem_req_tid); end
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL exh_reuse_valid got %b exp 1", mem_req_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mem_req_ready = 1'b0;
    req_valid     = 3'b100;
    req[2]        = 128'hBEEF;
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL bp_first_grant got %b exp 100", req_ready); end
    tick();
    req_valid = 3'b101;
    req[0]    = 128'h0A0A;
    req[2]    = 128'hC0DE;
    for (int unsigned c = 1; c <= 5; c++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000)  begin n_err++; $display("FAIL bp_stall_grant c%0d got %b exp 000", c, req_ready); end
      n_cmp++; if (mem_req !== 128'hBEEF) begin n_err++; $display("FAIL bp_stall_payload c%0d got %h exp beef", c, mem_req); end
      n_cmp++; if (mem_req_tid !== 2'd0 || mem_req_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall_slot c%0d got tid %0d valid %b exp tid 0 valid 1", c, mem_req_tid, mem_req_valid); end
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL bp_release_grant got %b exp 001", req_ready); end
    tick();
    req_valid = 3'b100;
    #1;
    n_cmp++; if (mem_req !== 128'h0A0A || mem_req_tid !== 2'd1) begin n_err++; $display("FAIL bp_next_slot got %h tid %0d exp a0a tid 1", mem_req, mem_req_tid); end
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL bp_back_to_back got %b exp 100", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_drain();
    apply_reset();
    mem_req_ready = 1'b1;
    req_valid     = 3'b111;
    tick();
    tick();
    tick();
    req_valid = '0;
    drain     = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL drain_enter_grant got %b exp 000", req_ready); end
    tick();
    req_valid = 3'b011;
    for (int unsigned t = 0; t < 3; t++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tid   = TidWidth'(t);
      #1;
      n_cmp++; if (req_ready !== 3'b000)  begin n_err++; $display("FAIL drain_block t%0d got %b exp 000", t, req_ready); end
      n_cmp++; if (drain_done !== 1'b0)   begin n_err++; $display("FAIL drain_early_done t%0d got %b exp 0", t, drain_done); end
      n_cmp++; if (rsp_valid !== 3'(1 << t)) begin n_err++; $display("FAIL drain_rsp t%0d got %b exp %b", t, rsp_valid, 3'(1 << t)); end
      tick();
    end
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (drain_done !== 1'b1) begin n_err++; $display("FAIL drain_done got %b exp 1", drain_done); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL drain_busy got %b exp 0", busy); end
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL drained_grant got %b exp 000", req_ready); end
    tick();
    drain = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL drained_exit_grant got %b exp 000", req_ready); end
    tick();
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL drain_resume got %b exp 001", req_ready); end
    n_cmp++; if (drain_done !== 1'b0)  begin n_err++; $display("FAIL drain_done_clear got %b exp 0", drain_done); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem_req_ready = 1'b1;
    req_valid     = 3'b001;
    tick();
    req_valid = 3'b010;
    tick();
    req_valid     = '0;
    mem_req_ready = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1 || mem_req_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got busy %b valid %b exp 1 1", busy, mem_req_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b exp 0", mem_req_valid); end
    n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
    mem_rsp_valid = 1'b1;
    mem_rsp_tid   = 2'd1;
    #1;
    n_cmp++; if (rsp_valid !== 3'b000) begin n_err++; $display("FAIL mid_late_rsp got %b exp 000", rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = '0;
    req           = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_tid   = '0;
    mem_rsp       = '0;
    drain         = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_exhaustion();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
